// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus among NUM_MASTERS request/ready/fault masters.
// Latency: request to bus drive 1 cycle (grant registered); completion reported in the slave's ready cycle.
// Backpressure: grant held until ready_in (or fault); masters hold request stable until their ready pulse.
// Optional macro BUS_TIMEOUT_EN adds a wait counter that forces a fault after TIMEOUT_CYCLES stalled cycles.
module rr_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [32*NUM_MASTERS-1:0] m_address_in,
  input  logic [NUM_MASTERS-1:0]    m_read_in,
  input  logic [NUM_MASTERS-1:0]    m_write_in,
  input  logic [4*NUM_MASTERS-1:0]  m_write_mask_in,
  input  logic [32*NUM_MASTERS-1:0] m_write_value_in,
  output logic [32*NUM_MASTERS-1:0] m_read_value_out,
  output logic [NUM_MASTERS-1:0]    m_ready_out,
  output logic [NUM_MASTERS-1:0]    m_fault_out,
  output logic [31:0]               address_out,
  output logic                      read_out,
  output logic                      write_out,
  output logic [3:0]                write_mask_out,
  output logic [31:0]               write_value_out,
  input  logic [31:0]               read_value_in,
  input  logic                      ready_in,
  input  logic                      fault_in,
  output logic [NUM_MASTERS-1:0]    grant_out
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic                   state;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       last_grant;

  logic [NUM_MASTERS-1:0] req;
  logic                   pick_vld;
  logic [IDX_W-1:0]       pick_idx;

  logic busy;
  logic own_req;
  logic done_ok;
  logic abort;
  logic timeout_hit;
  logic bus_on;

  assign req       = m_read_in | m_write_in;
  assign busy      = (state == ST_BUSY);
  assign own_req   = req[owner];
  assign grant_out = grant;

  // A completing slave always wins; the owner keeps the bus even if it withdrew this cycle.
  assign done_ok = busy && ready_in;
  // Owner dropped its request without being served: protocol violation, leave silently.
  assign abort   = busy && !ready_in && !own_req;

`ifdef BUS_TIMEOUT_EN
  localparam int                CNT_W   = 16;
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Count stalled BUSY cycles; IDLE holds it at zero so every grant starts fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!busy) begin
      wait_cnt <= '0;
    end else if (!ready_in) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The TIMEOUT_CYCLES-th stalled cycle is the one where the count still reads TIMEOUT_CYCLES-1.
  assign timeout_hit = busy && !ready_in && own_req && (wait_cnt == TO_LAST);
`else
  // Without the timeout the parameter is accepted but inert; BUSY waits for ready_in forever.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // The bus is released in the forced-fault cycle so the stuck slave sees the access end.
  assign bus_on = busy && !timeout_hit;

  // Rotating priority: scan last_grant+1 .. last_grant+N; descending loop lets the nearest requester win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NUM_MASTERS]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'((int'(last_grant) + k) % NUM_MASTERS);
      end
    end
  end

  // Common bus: mux of the owner's inputs while BUSY, quiet otherwise; mask only meaningful on writes.
  always_comb begin
    address_out     = '0;
    read_out        = 1'b0;
    write_out       = 1'b0;
    write_mask_out  = '0;
    write_value_out = '0;
    if (bus_on) begin
      address_out     = m_address_in[32*owner +: 32];
      read_out        = m_read_in[owner];
      write_out       = m_write_in[owner];
      write_value_out = m_write_value_in[32*owner +: 32];
      if (m_write_in[owner]) begin
        write_mask_out = m_write_mask_in[4*owner +: 4];
      end
    end
  end

  // Per-master return path: only the owner ever sees ready/fault/data, and only in its completion cycle.
  always_comb begin
    m_ready_out      = '0;
    m_fault_out      = '0;
    m_read_value_out = '0;
    if (done_ok) begin
      m_ready_out[owner]                = 1'b1;
      m_fault_out[owner]                = fault_in;
      m_read_value_out[32*owner +: 32]  = read_value_in;
    end else if (timeout_hit) begin
      m_ready_out[owner] = 1'b1;
      m_fault_out[owner] = 1'b1;
    end
  end

  // Arbitration state: grant in IDLE, hold through BUSY, rotate priority only on a reported completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state <= ST_BUSY;
            grant <= NUM_MASTERS'(1) << pick_idx;
            owner <= pick_idx;
          end
        end
        ST_BUSY: begin
          if (done_ok || timeout_hit) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= owner;
          end else if (abort) begin
            state <= ST_IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Randomized and directed bench for rr_bus_arbiter against a transaction-level reference model.
// Latency: model predicts every output per cycle; inputs change #1 after posedge, outputs sampled at negedge.
// Backpressure: masters hold requests until the model reports their completion.
module tb_rr_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [32*N-1:0] m_address_in;
  logic [N-1:0]    m_read_in;
  logic [N-1:0]    m_write_in;
  logic [4*N-1:0]  m_write_mask_in;
  logic [32*N-1:0] m_write_value_in;
  logic [32*N-1:0] m_read_value_out;
  logic [N-1:0]    m_ready_out;
  logic [N-1:0]    m_fault_out;
  logic [31:0]     address_out;
  logic            read_out;
  logic            write_out;
  logic [3:0]      write_mask_out;
  logic [31:0]     write_value_out;
  logic [31:0]     read_value_in;
  logic            ready_in;
  logic            fault_in;
  logic [N-1:0]    grant_out;

  rr_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address_in(m_address_in), .m_read_in(m_read_in), .m_write_in(m_write_in),
    .m_write_mask_in(m_write_mask_in), .m_write_value_in(m_write_value_in),
    .m_read_value_out(m_read_value_out), .m_ready_out(m_ready_out), .m_fault_out(m_fault_out),
    .address_out(address_out), .read_out(read_out), .write_out(write_out),
    .write_mask_out(write_mask_out), .write_value_out(write_value_out),
    .read_value_in(read_value_in), .ready_in(ready_in), .fault_in(fault_in),
    .grant_out(grant_out)
  );

  always #5 clk = ~clk;

  // Bench-side master and slave intent.
  bit          b_rd[N];
  bit          b_wr[N];
  logic [31:0] b_addr[N];
  logic [31:0] b_wdata[N];
  logic [3:0]  b_mask[N];
  bit          s_rdy;
  bit          s_flt;
  logic [31:0] s_rval;

  // Reference model: who owns the bus (-1 = nobody), who was last served, stall length.
  int       mdl_owner;
  int       mdl_last;
  int       mdl_stall;
  bit [N-1:0] done_mask;
  int       grant_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_owner = -1;
    mdl_last  = N - 1;
    mdl_stall = 0;
    done_mask = '0;
  endtask

  task automatic clear_masters();
    for (int i = 0; i < N; i++) begin
      b_rd[i] = 1'b0;
      b_wr[i] = 1'b0;
      b_addr[i] = '0;
      b_wdata[i] = '0;
      b_mask[i] = '0;
    end
    s_rdy = 1'b0;
    s_flt = 1'b0;
    s_rval = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      m_address_in[32*i +: 32]     = b_addr[i];
      m_write_value_in[32*i +: 32] = b_wdata[i];
      m_write_mask_in[4*i +: 4]    = b_mask[i];
      m_read_in[i]                 = b_rd[i];
      m_write_in[i]                = b_wr[i];
    end
    ready_in      = s_rdy;
    fault_in      = s_flt;
    read_value_in = s_rval;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_grant"}, grant_out, '0);
    check_eq({tag, "_bus"}, {address_out, read_out, write_out, write_mask_out, write_value_out}, '0);
    check_eq({tag, "_ret"}, {m_ready_out, m_fault_out, m_read_value_out}, '0);
  endtask

  // Predict this cycle's outputs from the model, compare, then advance the model.
  task automatic check_and_update();
    logic [N-1:0]    e_grant = '0;
    logic [31:0]     e_addr = '0;
    logic            e_rd = 1'b0;
    logic            e_wr = 1'b0;
    logic [3:0]      e_mask = '0;
    logic [31:0]     e_wdata = '0;
    logic [N-1:0]    e_rdy = '0;
    logic [N-1:0]    e_flt = '0;
    logic [32*N-1:0] e_rval = '0;
    bit tmo = 1'b0;
    bit req_g = 1'b0;
    int g;
    done_mask = '0;
    g = mdl_owner;
    if (g >= 0) begin
      req_g = b_rd[g] | b_wr[g];
`ifdef BUS_TIMEOUT_EN
      if (!s_rdy && req_g && (mdl_stall + 1 == TO)) tmo = 1'b1;
`endif
      e_grant[g] = 1'b1;
      if (!tmo) begin
        e_addr  = b_addr[g];
        e_rd    = b_rd[g];
        e_wr    = b_wr[g];
        e_mask  = b_wr[g] ? b_mask[g] : 4'h0;
        e_wdata = b_wdata[g];
      end
      if (s_rdy) begin
        e_rdy[g] = 1'b1;
        e_flt[g] = s_flt;
        e_rval[32*g +: 32] = s_rval;
      end else if (tmo) begin
        e_rdy[g] = 1'b1;
        e_flt[g] = 1'b1;
      end
    end
    check_eq("grant", grant_out, e_grant);
    check_eq("address", address_out, e_addr);
    check_eq("rw", {read_out, write_out}, {e_rd, e_wr});
    check_eq("mask", write_mask_out, e_mask);
    check_eq("wdata", write_value_out, e_wdata);
    check_eq("ready", m_ready_out, e_rdy);
    check_eq("fault", m_fault_out, e_flt);
    check_eq("rdata", m_read_value_out, e_rval);
    if (g >= 0) begin
      if (s_rdy || tmo) begin
        mdl_last  = g;
        mdl_owner = -1;
        done_mask[g] = 1'b1;
        grant_log.push_back(g);
      end else if (!req_g) begin
        mdl_owner = -1;
      end else begin
        mdl_stall++;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int idx = (mdl_last + k) % N;
        if (mdl_owner < 0 && (b_rd[idx] || b_wr[idx])) begin
          mdl_owner = idx;
          mdl_stall = 0;
        end
      end
    end
  endtask

  // One clock: apply inputs, check at negedge, retire served masters.
  task automatic run_cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_and_update();
    for (int i = 0; i < N; i++) begin
      if (done_mask[i]) begin
        b_rd[i] = 1'b0;
        b_wr[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_masters();
    drive();
    #1;
    check_quiet("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic new_random_txn(input int i);
    int kind = int'($urandom_range(0, 3));
    b_rd[i]    = (kind != 2);
    b_wr[i]    = (kind >= 2);
    b_addr[i]  = $urandom;
    b_wdata[i] = $urandom;
    b_mask[i]  = 4'($urandom_range(0, 15));
  endtask

  initial begin
    model_reset();
    clear_masters();
    drive();
    do_reset();

    // Single read by master 1; slave holds off one BUSY cycle then returns data.
    b_rd[1] = 1'b1;
    b_addr[1] = 32'h0000_0010;
    run_cycle();
    check_eq("rd_idle_addr", address_out, 32'h0);
    run_cycle();
    check_eq("rd_drive_addr", address_out, 32'h0000_0010);
    s_rdy = 1'b1;
    s_rval = 32'hCAFE_0010;
    run_cycle();
    check_eq("rd_ready", m_ready_out, 3'b010);
    check_eq("rd_data", m_read_value_out, {32'h0, 32'hCAFE_0010, 32'h0});
    run_cycle();
    check_eq("rd_after_grant", grant_out, 3'b000);

    // Rotation: everyone requests continuously against a single-cycle slave.
    do_reset();
    s_rdy = 1'b1;
    grant_log.delete();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!b_rd[i]) begin
          b_rd[i] = 1'b1;
          b_addr[i] = 32'h100 * (i + 1) + c;
        end
      end
      run_cycle();
    end
    check_eq("rot_count", grant_log.size(), 6);
    for (int t = 0; t < grant_log.size() && t < 6; t++) begin
      check_eq($sformatf("rot_order%0d", t), grant_log[t], t % N);
    end

    // Decoder fault on master 2 while master 0 idles.
    clear_masters();
    run_cycle();
    b_rd[2] = 1'b1;
    b_addr[2] = 32'h0005_0000;
    s_rdy = 1'b1;
    s_flt = 1'b1;
    run_cycle();
    run_cycle();
    check_eq("flt_pulse", {m_ready_out, m_fault_out}, {3'b100, 3'b100});
    s_flt = 1'b0;

    // Write gating: master 0 writes while master 1 reads.
    b_wr[0] = 1'b1; b_addr[0] = 32'h2000_0000; b_wdata[0] = 32'h1234_5678; b_mask[0] = 4'b0011;
    b_rd[1] = 1'b1; b_addr[1] = 32'h2000_0004; b_mask[1] = 4'b1111;
    run_cycle();
    run_cycle();
    check_eq("wr_mask_on", write_mask_out, 4'b0011);
    run_cycle();
    run_cycle();
    check_eq("wr_mask_read", write_mask_out, 4'b0000);

    // Abort: master 1 withdraws mid-BUSY; priority must not rotate past it.
    run_cycle();
    s_rdy = 1'b0;
    b_rd[1] = 1'b1; b_addr[1] = 32'h3000_0000;
    run_cycle();
    run_cycle();
    b_rd[1] = 1'b0;
    run_cycle();
    check_eq("abort_noready", m_ready_out, 3'b000);
    b_rd[0] = 1'b1; b_rd[2] = 1'b1;
    s_rdy = 1'b1;
    run_cycle();
    run_cycle();
    check_eq("abort_next", grant_out, 3'b100);
    run_cycle();
    run_cycle();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!b_rd[i] && !b_wr[i] && ($urandom_range(0, 2) == 0)) new_random_txn(i);
      end
      s_rdy  = ($urandom_range(0, 2) != 0);
      s_flt  = ($urandom_range(0, 7) == 0);
      s_rval = $urandom;
      run_cycle();
    end

    // Stalled slave: forced fault with the timeout, indefinite wait without it.
    do_reset();
    b_rd[0] = 1'b1; b_addr[0] = 32'h4000_0000;
    b_rd[2] = 1'b1; b_addr[2] = 32'h4000_0008;
    s_rval = 32'hDEAD_BEEF;
`ifdef BUS_TIMEOUT_EN
    for (int c = 0; c < 5; c++) run_cycle();
    check_eq("to_pulse", {m_ready_out, m_fault_out}, {3'b001, 3'b001});
    check_eq("to_rdata", m_read_value_out, '0);
    run_cycle();
    run_cycle();
    check_eq("to_rearb", grant_out, 3'b100);
`else
    for (int c = 0; c < 9; c++) run_cycle();
    check_eq("stall_hold", grant_out, 3'b001);
`endif
    run_cycle();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_quiet("async_rst");
    clear_masters();
    drive();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
